mem_in_reader: RTL

Read sequencer for the banked input memory. On a start command it streams `length` consecutive bytes out of the input memory through a valid/ready interface to the systolic-array feed logic. It drives the memory's active-low chip enable and write enable, address and read data. It absorbs the memory's one-cycle read latency and downstream backpressure with a 2-entry skid FIFO.

---
 rtl/mem_in_reader_if.sv | 9 +
 rtl/mem_in_reader.sv | 134 +++++++++++++
 2 files changed

// File: rtl/mem_in_reader_if.sv
// Byte stream handshake from the input-memory read sequencer to the systolic-array feed.
interface mem_in_reader_if;
  logic       valid;
  logic [7:0] data;
  logic       ready;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/mem_in_reader.sv
// Read sequencer: streams `length` bytes from the banked input memory through a 2-entry skid FIFO.
// Optional MEM_IN_READER_STRIDE_EN adds a captured `stride` port for the address increment.
module mem_in_reader #(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [LEN_W-1:0]  length,
`ifdef MEM_IN_READER_STRIDE_EN
  input  logic [ADDR_W-1:0] stride,
`endif
  output logic              busy,
  output logic              done,
  output logic              mem_CEN,
  output logic              mem_WEN,
  output logic [ADDR_W-1:0] mem_A,
  input  logic [7:0]        mem_Q,
  mem_in_reader_if.master   out
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t            state;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] a_last;
  logic [ADDR_W-1:0] step;
  logic [LEN_W-1:0]  len;
  logic [LEN_W-1:0]  issued;
  logic [LEN_W-1:0]  popped;
  logic              inflight;
  logic [7:0]        fifo_mem [2];
  logic              rd_ptr;
  logic [1:0]        count;
  logic [1:0]        occ_after;
  logic              fifo_empty;
  logic              pop;
  logic              pop_store;
  logic              push_store;
  logic              issue;

`ifdef MEM_IN_READER_STRIDE_EN
  logic [ADDR_W-1:0] stride_q;
  assign step = stride_q;
`else
  assign step = ADDR_W'(1);
`endif

  // The byte returning from memory is presented directly when the FIFO is empty,
  // so the first byte appears the cycle after its read without an extra bubble.
  assign fifo_empty = (count == 2'd0);
  assign out.valid  = !fifo_empty || inflight;
  assign out.data   = !fifo_empty ? fifo_mem[rd_ptr] : (inflight ? mem_Q : 8'h00);
  assign pop        = out.valid && out.ready;
  assign pop_store  = pop && !fifo_empty;
  assign push_store = inflight && !(fifo_empty && pop);

  // Occupancy once this cycle's pop and returning byte settle; never exceeds 2.
  assign occ_after = count + 2'(inflight) - 2'(pop);
  assign issue     = (state == RUN) && (issued != len) && (occ_after < 2'd2);

  assign mem_CEN = !issue;
  assign mem_WEN = 1'b1;
  assign mem_A   = issue ? addr : a_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      addr        <= '0;
      a_last      <= '0;
      len         <= '0;
      issued      <= '0;
      popped      <= '0;
      inflight    <= 1'b0;
      fifo_mem[0] <= 8'h00;
      fifo_mem[1] <= 8'h00;
      rd_ptr      <= 1'b0;
      count       <= 2'd0;
`ifdef MEM_IN_READER_STRIDE_EN
      stride_q    <= '0;
`endif
    end else begin
      done     <= 1'b0;
      inflight <= issue;
      if (issue) begin
        a_last <= addr;
        addr   <= addr + step;
        issued <= issued + LEN_W'(1);
      end
      if (pop) popped <= popped + LEN_W'(1);
      if (push_store) fifo_mem[rd_ptr ^ count[0]] <= mem_Q;
      if (pop_store) rd_ptr <= !rd_ptr;
      count <= count + 2'(push_store) - 2'(pop_store);

      case (state)
        IDLE: begin
          if (start) begin
            addr   <= base_addr;
            len    <= length;
            issued <= '0;
            popped <= '0;
`ifdef MEM_IN_READER_STRIDE_EN
            stride_q <= stride;
`endif
            if (length == '0) begin
              state <= DONE;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
            end
          end
        end
        RUN: begin
          if (issue && (issued == len - LEN_W'(1))) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (popped == len - LEN_W'(1))) begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
